addr_decoding_multi: RTL and testbench
======================================

Name: addr_decoding_multi

Overview:
Parametrised successor to the single-region program-memory address decoder. It decodes one CPU address per cycle into three regions: program memory, data memory and memory-mapped I/O. For each address it produces a registered one-hot chip select and a region-relative local address. It also detects misaligned and unmapped accesses, keeps a sticky fault status with the captured fault address, and counts valid accesses. It sits between the CPU address bus and the memory and peripheral blocks.

Parameters:
ADDR_WIDTH, 32, width of address_in
OUT_WIDTH, 10, width of address_out; 2^OUT_WIDTH must be >= each region's SIZE
PROG_BASE, 32'h31b0, first byte address of the program region
PROG_SIZE, 32'h400, program region size in bytes
DATA_BASE, 32'h2000, first byte address of the data region
DATA_SIZE, 32'h400, data region size in bytes
IO_BASE, 32'h4000, first byte address of the I/O region
IO_SIZE, 32'h100, I/O region size in bytes
ALIGN_CHECK, 1, 1 = a word access with address_in[1:0] != 0 is a fault
CNT_WIDTH, 16, width of the access counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous reset, active low
req  input  1  address_in is valid this cycle
address_in  input  ADDR_WIDTH  CPU byte address
fault_clr  input  1  clears the sticky fault status
cs_p  output  1  program memory select, registered
cs_d  output  1  data memory select, registered
cs_io  output  1  I/O select, registered
address_out  output  OUT_WIDTH  (address_in - selected BASE)[OUT_WIDTH-1:0], registered
misalign  output  1  one-cycle pulse: the current access is misaligned
unmapped  output  1  one-cycle pulse: the current access hits no region
fault  output  1  sticky: a misaligned or unmapped access has occurred
fault_addr  output  ADDR_WIDTH  address of the first fault since the last clear
access_cnt  output  CNT_WIDTH  number of valid req cycles, saturating

Behaviour:
- Reset (rst_n low, asynchronous): all outputs go to 0 immediately and stay 0 while rst_n is low.
- Latency: 1 cycle. Outputs on edge N+1 reflect req and address_in sampled at edge N.
- Region hit: BASE <= address_in <= BASE+SIZE-1, compared at full ADDR_WIDTH with no wrap. If BASE+SIZE overflows, the region is clipped at 2^ADDR_WIDTH-1.
- Overlap priority: prog > data > io. At most one cs output is high in any cycle.
- req = 0: cs_p, cs_d, cs_io, misalign and unmapped are 0; address_out holds its last value; the counter and fault registers are unchanged.
- Misaligned access (ALIGN_CHECK = 1, req = 1, address_in[1:0] != 0): all cs outputs 0, misalign = 1, address_out holds its last value. Misalign takes precedence over a region hit.
- Unmapped access (req = 1, aligned, no region hit): all cs outputs 0, unmapped = 1.
- Fault set: on a misaligned or unmapped access, fault is set to 1. fault_addr captures address_in only if fault was 0 (first fault wins).
- fault_clr = 1: fault and fault_addr return to 0 on the next edge.
- fault_clr in the same cycle as a new fault: the new fault wins; fault = 1 and fault_addr = the new address.
- access_cnt: increments on every req = 1 cycle, including faulting ones. It saturates at 2^CNT_WIDTH-1 and does not wrap. It is cleared only by reset.
- Reset mid-stream: any access in flight is discarded; the first edge after rst_n rises decodes normally.
- Elaboration check: an error is raised if any SIZE > 2^OUT_WIDTH.

Test Plan:
- Sweep req = 1 over address_in 0x31b0..0x35af in steps of 4 -> next cycle cs_p = 1 and address_out = 0x000..0x3fc (address_in - 0x31b0); cs_d = cs_io = 0; access_cnt = 256.
- Boundaries: 0x31ac -> unmapped = 1, fault = 1, fault_addr = 0x31ac. 0x35b0 -> unmapped = 1, fault_addr still 0x31ac. 0x23fc -> cs_d = 1, address_out = 0x3fc. 0x4000 -> cs_io = 1, address_out = 0.
- Misaligned 0x31b2 -> misalign = 1, all cs outputs 0, address_out unchanged. With ALIGN_CHECK = 0, the same address gives cs_p = 1 and address_out = 0x002.
- fault = 1, then fault_clr asserted together with an unmapped 0x9000 -> fault stays 1 and fault_addr = 0x9000. fault_clr alone in the next cycle -> fault = 0, fault_addr = 0.
- CNT_WIDTH = 4, 20 req cycles -> access_cnt stops at 15.
- Assert rst_n low between clock edges in the middle of the sweep -> all outputs go to 0 before the next edge. After release, the first address 0x2000 gives cs_d = 1 and access_cnt = 1.

Source files
------------

// File: rtl/addr_decoding_multi.sv
`default_nettype none
// ============================================================================
// Module      : addr_decoding_multi
// Description : Decodes one CPU byte address per cycle into program, data
//               and I/O regions. Produces a registered one-hot chip select
//               and region-relative address, flags misaligned and unmapped
//               accesses, keeps a sticky fault with the first fault address,
//               and counts valid accesses with saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module addr_decoding_multi #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    OUT_WIDTH   = 10,
  parameter logic [ADDR_WIDTH-1:0] PROG_BASE   = 'h31b0,
  parameter logic [ADDR_WIDTH:0]   PROG_SIZE   = 'h400,
  parameter logic [ADDR_WIDTH-1:0] DATA_BASE   = 'h2000,
  parameter logic [ADDR_WIDTH:0]   DATA_SIZE   = 'h400,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE     = 'h4000,
  parameter logic [ADDR_WIDTH:0]   IO_SIZE     = 'h100,
  parameter int                    ALIGN_CHECK = 1,
  parameter int                    CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] address_in,
  input  logic                  fault_clr,
  output logic                  cs_p,
  output logic                  cs_d,
  output logic                  cs_io,
  output logic [OUT_WIDTH-1:0]  address_out,
  output logic                  misalign,
  output logic                  unmapped,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] fault_addr,
  output logic [CNT_WIDTH-1:0]  access_cnt
);

  // Each region must fit in the local address space.
  localparam logic [63:0] c_span = 64'd1 << OUT_WIDTH;

  if ((64'(PROG_SIZE) > c_span) || (64'(DATA_SIZE) > c_span) ||
      (64'(IO_SIZE) > c_span)) begin : g_size_err
    $error("addr_decoding_multi: a region SIZE exceeds 2^OUT_WIDTH");
  end

  // One extra bit keeps BASE+SIZE from wrapping, so a region that runs past
  // the top of the address space is naturally clipped there.
  function automatic logic in_region(input logic [ADDR_WIDTH-1:0] a,
                                     input logic [ADDR_WIDTH-1:0] base,
                                     input logic [ADDR_WIDTH:0]   size);
    logic [ADDR_WIDTH:0] end_excl;
    end_excl = {1'b0, base} + size;
    return ({1'b0, a} >= {1'b0, base}) && ({1'b0, a} < end_excl);
  endfunction

  logic                  w_bad_align;
  logic                  w_hit_p;
  logic                  w_hit_d;
  logic                  w_hit_io;
  logic                  w_any_hit;
  logic                  w_sel;
  logic                  w_mis;
  logic                  w_unm;
  logic                  w_new_fault;
  logic [ADDR_WIDTH-1:0] w_base;
  logic [OUT_WIDTH-1:0]  w_offset;

  // Region decode with prog > data > io priority; misalignment masks any hit.
  always_comb begin
    w_bad_align = (ALIGN_CHECK != 0) && (address_in[1:0] != 2'b00);
    w_hit_p     = in_region(address_in, PROG_BASE, PROG_SIZE);
    w_hit_d     = !w_hit_p && in_region(address_in, DATA_BASE, DATA_SIZE);
    w_hit_io    = !w_hit_p && !w_hit_d && in_region(address_in, IO_BASE, IO_SIZE);
    w_any_hit   = w_hit_p || w_hit_d || w_hit_io;
    w_sel       = req && !w_bad_align && w_any_hit;
    w_mis       = req && w_bad_align;
    w_unm       = req && !w_bad_align && !w_any_hit;
    w_new_fault = w_mis || w_unm;
    w_base      = PROG_BASE;
    if (w_hit_d) begin
      w_base = DATA_BASE;
    end else if (w_hit_io) begin
      w_base = IO_BASE;
    end
    w_offset = OUT_WIDTH'(address_in - w_base);
  end

  // Registered chip selects, local address and per-access status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_p        <= 1'b0;
      cs_d        <= 1'b0;
      cs_io       <= 1'b0;
      misalign    <= 1'b0;
      unmapped    <= 1'b0;
      address_out <= '0;
    end else begin
      cs_p     <= w_sel && w_hit_p;
      cs_d     <= w_sel && w_hit_d;
      cs_io    <= w_sel && w_hit_io;
      misalign <= w_mis;
      unmapped <= w_unm;
      if (w_sel) begin
        address_out <= w_offset;
      end
    end
  end

  // Sticky fault: first fault address is kept; a new fault beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault      <= 1'b0;
      fault_addr <= '0;
    end else if (w_new_fault) begin
      fault <= 1'b1;
      if (!fault || fault_clr) begin
        fault_addr <= address_in;
      end
    end else if (fault_clr) begin
      fault      <= 1'b0;
      fault_addr <= '0;
    end
  end

  // Saturating count of every valid request cycle, faulting ones included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      access_cnt <= '0;
    end else if (req && (access_cnt != {CNT_WIDTH{1'b1}})) begin
      access_cnt <= access_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_addr_decoding_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_addr_decoding_multi
// Description : Self-checking bench for addr_decoding_multi. Three instances
//               share one stimulus: default, ALIGN_CHECK=0 and CNT_WIDTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addr_decoding_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0;
  logic [31:0] address_in = '0;
  logic        fault_clr = 1'b0;

  logic        cs_p, cs_d, cs_io, misalign, unmapped, fault;
  logic [9:0]  address_out;
  logic [31:0] fault_addr;
  logic [15:0] access_cnt;

  logic        na_cs_p, na_cs_d, na_cs_io, na_misalign, na_unmapped, na_fault;
  logic [9:0]  na_address_out;
  logic [31:0] na_fault_addr;
  logic [15:0] na_access_cnt;

  logic        c4_cs_p, c4_cs_d, c4_cs_io, c4_misalign, c4_unmapped, c4_fault;
  logic [9:0]  c4_address_out;
  logic [31:0] c4_fault_addr;
  logic [3:0]  c4_access_cnt;

  int nerr = 0;
  int nchk = 0;
  int ref_cnt = 0;

  always #5 clk = ~clk;

  addr_decoding_multi dut (
    .clk(clk), .rst_n(rst_n), .req(req), .address_in(address_in),
    .fault_clr(fault_clr), .cs_p(cs_p), .cs_d(cs_d), .cs_io(cs_io),
    .address_out(address_out), .misalign(misalign), .unmapped(unmapped),
    .fault(fault), .fault_addr(fault_addr), .access_cnt(access_cnt)
  );

  addr_decoding_multi #(.ALIGN_CHECK(0)) dut_na (
    .clk(clk), .rst_n(rst_n), .req(req), .address_in(address_in),
    .fault_clr(fault_clr), .cs_p(na_cs_p), .cs_d(na_cs_d), .cs_io(na_cs_io),
    .address_out(na_address_out), .misalign(na_misalign),
    .unmapped(na_unmapped), .fault(na_fault), .fault_addr(na_fault_addr),
    .access_cnt(na_access_cnt)
  );

  addr_decoding_multi #(.CNT_WIDTH(4)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .req(req), .address_in(address_in),
    .fault_clr(fault_clr), .cs_p(c4_cs_p), .cs_d(c4_cs_d), .cs_io(c4_cs_io),
    .address_out(c4_address_out), .misalign(c4_misalign),
    .unmapped(c4_unmapped), .fault(c4_fault), .fault_addr(c4_fault_addr),
    .access_cnt(c4_access_cnt)
  );

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        clr;
    logic        cs_p;
    logic        cs_d;
    logic        cs_io;
    logic [9:0]  ao;
    logic        mis;
    logic        unm;
    logic        flt;
    logic [31:0] fa;
    logic        na_cs_p;
    logic [9:0]  na_ao;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and return 1 time unit after the sampling edge.
  task automatic step(input logic r, input logic [31:0] a, input logic c);
    @(negedge clk);
    req = r;
    address_in = a;
    fault_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cs_p"}, 64'(cs_p), 0);
    chk({tag, "_cs_d"}, 64'(cs_d), 0);
    chk({tag, "_cs_io"}, 64'(cs_io), 0);
    chk({tag, "_addr_out"}, 64'(address_out), 0);
    chk({tag, "_misalign"}, 64'(misalign), 0);
    chk({tag, "_unmapped"}, 64'(unmapped), 0);
    chk({tag, "_fault"}, 64'(fault), 0);
    chk({tag, "_fault_addr"}, 64'(fault_addr), 0);
    chk({tag, "_cnt"}, 64'(access_cnt), 0);
  endtask

  initial begin
    // Table state follows the full program sweep: address_out = 0x3fc, no fault.
    //          req addr      clr p  d  io ao      mis unm flt fa        nap na_ao
    tbl[0]  = '{1, 32'h31ac, 0, 0, 0, 0, 10'h3fc, 0, 1, 1, 32'h31ac, 0, 10'h3fc};
    tbl[1]  = '{1, 32'h35b0, 0, 0, 0, 0, 10'h3fc, 0, 1, 1, 32'h31ac, 0, 10'h3fc};
    tbl[2]  = '{1, 32'h23fc, 0, 0, 1, 0, 10'h3fc, 0, 0, 1, 32'h31ac, 0, 10'h3fc};
    tbl[3]  = '{1, 32'h4000, 0, 0, 0, 1, 10'h000, 0, 0, 1, 32'h31ac, 0, 10'h000};
    tbl[4]  = '{1, 32'h40fc, 0, 0, 0, 1, 10'h0fc, 0, 0, 1, 32'h31ac, 0, 10'h0fc};
    tbl[5]  = '{1, 32'h4100, 0, 0, 0, 0, 10'h0fc, 0, 1, 1, 32'h31ac, 0, 10'h0fc};
    tbl[6]  = '{1, 32'h31b2, 0, 0, 0, 0, 10'h0fc, 1, 0, 1, 32'h31ac, 1, 10'h002};
    tbl[7]  = '{0, 32'h2000, 0, 0, 0, 0, 10'h0fc, 0, 0, 1, 32'h31ac, 0, 10'h002};
    tbl[8]  = '{1, 32'h31b0, 0, 1, 0, 0, 10'h000, 0, 0, 1, 32'h31ac, 1, 10'h000};
    tbl[9]  = '{1, 32'h35ac, 0, 1, 0, 0, 10'h3fc, 0, 0, 1, 32'h31ac, 1, 10'h3fc};
    tbl[10] = '{1, 32'h1ffc, 0, 0, 0, 0, 10'h3fc, 0, 1, 1, 32'h31ac, 0, 10'h3fc};
    tbl[11] = '{1, 32'h9000, 1, 0, 0, 0, 10'h3fc, 0, 1, 1, 32'h9000, 0, 10'h3fc};
    tbl[12] = '{0, 32'h0000, 1, 0, 0, 0, 10'h3fc, 0, 0, 0, 32'h0000, 0, 10'h3fc};
    tbl[13] = '{1, 32'h2001, 0, 0, 0, 0, 10'h3fc, 1, 0, 1, 32'h2001, 0, 10'h001};
    tbl[14] = '{1, 32'h2004, 0, 0, 1, 0, 10'h004, 0, 0, 1, 32'h2001, 0, 10'h004};
    tbl[15] = '{0, 32'h2004, 0, 0, 0, 0, 10'h004, 0, 0, 1, 32'h2001, 0, 10'h004};

    // Reset state
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Saturating counter on the CNT_WIDTH=4 instance
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'h2000 + 32'(i * 4), 1'b0);
      chk("c4_cnt", 64'(c4_access_cnt), (i + 1 < 15) ? 64'(i + 1) : 64'd15);
      chk("cnt20", 64'(access_cnt), 64'(i + 1));
      chk("cnt20_cs_d", 64'(cs_d), 1);
    end

    // Full program-region sweep after a fresh reset
    @(negedge clk);
    rst_n = 1'b0;
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 32'h31b0 + 32'(i * 4), 1'b0);
      chk("sweep_cs_p", 64'(cs_p), 1);
      chk("sweep_cs_d", 64'(cs_d | cs_io), 0);
      chk("sweep_addr_out", 64'(address_out), 64'(i * 4));
      chk("sweep_unmapped", 64'(unmapped | misalign), 0);
    end
    chk("sweep_cnt", 64'(access_cnt), 256);
    ref_cnt = 256;

    // Boundaries, misalignment, fault capture and clear
    for (int k = 0; k < 16; k++) begin
      step(tbl[k].req, tbl[k].addr, tbl[k].clr);
      if (tbl[k].req) ref_cnt++;
      chk($sformatf("v%0d_cs_p", k), 64'(cs_p), 64'(tbl[k].cs_p));
      chk($sformatf("v%0d_cs_d", k), 64'(cs_d), 64'(tbl[k].cs_d));
      chk($sformatf("v%0d_cs_io", k), 64'(cs_io), 64'(tbl[k].cs_io));
      chk($sformatf("v%0d_addr_out", k), 64'(address_out), 64'(tbl[k].ao));
      chk($sformatf("v%0d_misalign", k), 64'(misalign), 64'(tbl[k].mis));
      chk($sformatf("v%0d_unmapped", k), 64'(unmapped), 64'(tbl[k].unm));
      chk($sformatf("v%0d_fault", k), 64'(fault), 64'(tbl[k].flt));
      chk($sformatf("v%0d_fault_addr", k), 64'(fault_addr), 64'(tbl[k].fa));
      chk($sformatf("v%0d_na_cs_p", k), 64'(na_cs_p), 64'(tbl[k].na_cs_p));
      chk($sformatf("v%0d_na_addr_out", k), 64'(na_address_out), 64'(tbl[k].na_ao));
      chk($sformatf("v%0d_cnt", k), 64'(access_cnt), 64'(ref_cnt));
    end

    // Asynchronous reset in the middle of a sweep
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h31b0 + 32'(i * 4), 1'b0);
    end
    chk("pre_rst_cs_p", 64'(cs_p), 1);
    chk("pre_rst_fault", 64'(fault), 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    req = 1'b1;
    address_in = 32'h2000;
    fault_clr = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_cs_d", 64'(cs_d), 1);
    chk("post_rst_cs_p", 64'(cs_p), 0);
    chk("post_rst_addr_out", 64'(address_out), 0);
    chk("post_rst_cnt", 64'(access_cnt), 1);
    chk("post_rst_fault", 64'(fault), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
